// File: rtl/wb_slave_pkg.sv
// Shared definitions for the Wishbone register-bank responder:
// FSM state type, register word indices, miss read value and STATUS bit layout.
package wb_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } wb_state_t;

  localparam int unsigned REG_ID      = 0;
  localparam int unsigned REG_SCRATCH = 1;
  localparam int unsigned REG_COUNTER = 2;
  localparam int unsigned REG_STATUS  = 3;
  localparam int unsigned REG_CTRL    = 4;

  localparam logic [31:0] BAD_ADDR_DATA = 32'hBADA_DD00;

  localparam int unsigned STATUS_ERR_BIT = 0;
  localparam int unsigned STATUS_ACC_LSB = 16;
  localparam int unsigned STATUS_ACC_MSB = 31;

endpackage

// File: rtl/wb_reg_bank.sv
// Register storage for wb_slave_regs: ID, SCRATCH, COUNTER, STATUS, CTRL and GP
// words, plus the registered read mux.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_commit   - one-cycle strobe: commit the access on this edge
//   i_we       - access is a write
//   i_hit      - upper address bits matched the block base
//   i_idx      - word index
//   i_wdata    - write data
//   o_rdata    - read data, loaded on a committed read
//   o_ctrl     - live CTRL register
module wb_reg_bank
  import wb_slave_pkg::*;
#(
  parameter int unsigned AW       = 4,
  parameter logic [31:0] ID_VALUE = 32'h5742_5331
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_commit,
  input  logic          i_we,
  input  logic          i_hit,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata,
  output logic [31:0]   o_ctrl
);

  localparam int unsigned NREG = 1 << AW;

  localparam logic [AW-1:0] IDX_ID      = AW'(REG_ID);
  localparam logic [AW-1:0] IDX_SCRATCH = AW'(REG_SCRATCH);
  localparam logic [AW-1:0] IDX_COUNTER = AW'(REG_COUNTER);
  localparam logic [AW-1:0] IDX_STATUS  = AW'(REG_STATUS);
  localparam logic [AW-1:0] IDX_CTRL    = AW'(REG_CTRL);
  localparam logic [AW-1:0] IDX_GP0     = AW'(REG_CTRL + 1);

  logic [31:0] r_regs [NREG];
  logic [31:0] r_counter;
  logic        r_err;
  logic [15:0] r_acc;

  logic        w_wr;
  logic        w_rw_idx;
  logic        w_ro_wr;
  logic        w_err_set;
  logic        w_err_clr;
  logic [31:0] w_status;
  logic [31:0] w_rmux;

  always_comb begin
    w_wr      = i_commit & i_we & i_hit;
    w_rw_idx  = (i_idx == IDX_SCRATCH) | (i_idx == IDX_CTRL) | (i_idx >= IDX_GP0);
    // Only nonzero ACC_CNT bits count as a write to the RO field, so writing 1 clears ERR cleanly.
    w_ro_wr   = w_wr & ((i_idx == IDX_ID) |
                        ((i_idx == IDX_STATUS) & (i_wdata[STATUS_ACC_MSB:STATUS_ACC_LSB] != '0)));
    w_err_set = i_commit & (~i_hit | w_ro_wr);
    w_err_clr = w_wr & (i_idx == IDX_STATUS) & i_wdata[STATUS_ERR_BIT];

    w_status = '0;
    w_status[STATUS_ERR_BIT]                = r_err;
    w_status[STATUS_ACC_MSB:STATUS_ACC_LSB] = r_acc;

    w_rmux = r_regs[i_idx];
    if (!i_hit) begin
      w_rmux = BAD_ADDR_DATA;
    end else begin
      case (i_idx)
        IDX_ID:      w_rmux = ID_VALUE;
        // Report the value COUNTER takes on this edge (reads never coincide with a load).
        IDX_COUNTER: w_rmux = r_counter + 32'd1;
        IDX_STATUS:  w_rmux = w_status;
        default:     w_rmux = r_regs[i_idx];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs    <= '{default: '0};
      r_counter <= '0;
      r_err     <= 1'b0;
      r_acc     <= '0;
      o_rdata   <= '0;
    end else begin
      if (w_wr && (i_idx == IDX_COUNTER)) begin
        r_counter <= i_wdata;
      end else begin
        r_counter <= r_counter + 32'd1;
      end

      if (w_wr && w_rw_idx) begin
        r_regs[i_idx] <= i_wdata;
      end

      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end

      if (i_commit) begin
        r_acc <= r_acc + 16'd1;
        if (!i_we) begin
          o_rdata <= w_rmux;
        end
      end
    end
  end

  assign o_ctrl = r_regs[IDX_CTRL];

endmodule

// File: rtl/wb_slave_regs.sv
// Wishbone classic single-beat responder with a small register bank and
// configurable wait states.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   io_wb_data  - shared data bus; sampled for writes, driven only in a read ack cycle
//   i_wb_addr   - byte address
//   i_wb_we     - 1 = write, 0 = read
//   i_wb_cyc    - bus cycle active
//   i_wb_stb    - one-cycle request strobe
//   o_wb_ack    - one-cycle acknowledge
//   o_ctrl      - live CTRL register
module wb_slave_regs
  import wb_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned AW          = 4,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h5742_5331
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] io_wb_data,
  input  logic [31:0] i_wb_addr,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic        o_wb_ack,
  output logic [31:0] o_ctrl
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  wb_state_t r_state;
  wb_state_t w_state_nxt;

  logic [3:0]    r_wcnt;
  logic [3:0]    w_wcnt_nxt;
  logic          r_we;
  logic          r_hit;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;

  logic          w_req;
  logic          w_hit_live;
  logic          w_cap;
  logic          w_commit;
  logic          w_bk_we;
  logic          w_bk_hit;
  logic [AW-1:0] w_bk_idx;
  logic [31:0]   w_bk_wdata;
  logic [31:0]   w_rdata;
  logic          w_unused_addr_lsb;

  assign w_req             = i_wb_cyc & i_wb_stb;
  assign w_hit_live        = (i_wb_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign w_unused_addr_lsb = ^i_wb_addr[1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_cap       = 1'b0;
    w_commit    = 1'b0;
    w_bk_we     = r_we;
    w_bk_hit    = r_hit;
    w_bk_idx    = r_idx;
    w_bk_wdata  = r_wdata;

    case (r_state)
      ST_IDLE: begin
        // With zero wait states the commit lands on the capture edge, so feed the bank live.
        w_bk_we    = i_wb_we;
        w_bk_hit   = w_hit_live;
        w_bk_idx   = i_wb_addr[AW+1:2];
        w_bk_wdata = io_wb_data;
        if (w_req) begin
          w_cap = 1'b1;
          if (WAIT_INIT == '0) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_ACK;
          end else begin
            w_wcnt_nxt  = WAIT_INIT;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!i_wb_cyc) begin
          w_state_nxt = ST_IDLE;
        end else if (r_wcnt == 4'd1) begin
          w_commit    = 1'b1;
          w_wcnt_nxt  = '0;
          w_state_nxt = ST_ACK;
        end else begin
          w_wcnt_nxt  = r_wcnt - 4'd1;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_we    <= 1'b0;
      r_hit   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_cap) begin
        r_we    <= i_wb_we;
        r_hit   <= w_hit_live;
        r_idx   <= i_wb_addr[AW+1:2];
        r_wdata <= io_wb_data;
      end
    end
  end

  wb_reg_bank #(
    .AW       (AW),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .i_commit (w_commit),
    .i_we     (w_bk_we),
    .i_hit    (w_bk_hit),
    .i_idx    (w_bk_idx),
    .i_wdata  (w_bk_wdata),
    .o_rdata  (w_rdata),
    .o_ctrl   (o_ctrl)
  );

  assign o_wb_ack   = (r_state == ST_ACK);
  assign io_wb_data = ((r_state == ST_ACK) && !r_we && !i_wb_we) ? w_rdata : 'z;

endmodule

// File: doc/wb_slave_regs.md
# wb_slave_regs

Wishbone classic responder (slave) holding a small register bank, sitting on the far end of the wishbone master bus that the UART bridge drives. It decodes a single-beat cycle (`o_wb_cyc`/`o_wb_stb` from the master), inserts a configurable number of wait states, and commits the write or returns the read data. It then closes the cycle with a one-cycle `ack`. The write data and read data share the master's bidirectional data bus.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: the block responds when `i_wb_addr[31:AW+2]` equals `BASE_ADDR[31:AW+2]`.
- `AW`, default 4: word-index width, giving 16 words of 32 bits each; the word index is `i_wb_addr[AW+1:2]`.
- `WAIT_STATES`, default 1: extra cycles between request capture and `ack`, in the range 0..15.
- `ID_VALUE`, default 32'h5742_5331: constant returned by the ID register.

- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `io_wb_data`, inout, 32: driven only during a read `ack` cycle; Z otherwise. Write data is sampled from it.
- `i_wb_addr`, in, 32: byte address.
- `i_wb_we`, in, 1: 1 = write, 0 = read.
- `i_wb_cyc`, in, 1: bus cycle active.
- `i_wb_stb`, in, 1: request strobe; the master holds it for one cycle only.
- `o_wb_ack`, out, 1: one-cycle acknowledge.
- `o_ctrl`, out, 32: live copy of the CTRL register.

## Operation
- **FSM states:** IDLE, WAIT, ACK.
- **IDLE → request capture:** on `i_wb_cyc & i_wb_stb`, latch addr, we, `io_wb_data` and a hit flag. Load the wait counter with `WAIT_STATES`. Go to WAIT, or directly to ACK if `WAIT_STATES` is 0.
- **WAIT:** decrement the counter. When it reaches 0, go to ACK. If `i_wb_cyc` drops, abort to IDLE with no write, no ack and no counter side effects.
- **ACK:** `o_wb_ack` is 1 for exactly one cycle, then the FSM returns to IDLE. A `stb` seen in ACK is ignored.
- **Register map (word index):**
  - 0 ID: RO, returns `ID_VALUE`.
  - 1 SCRATCH: RW, reset 0.
  - 2 COUNTER: free-running +1 per clock, wraps at 2^32. A write loads the value, and the write wins over the increment on the same edge.
  - 3 STATUS: bit0 is ERR, a sticky flag for a miss or a write to an RO location; writing 1 clears it, and a new set on the same edge wins over the clear. Bits[31:16] are ACC_CNT, incremented on every ack (hits and misses) and wrapping at 16 bits. Other bits read 0. ACC_CNT is RO.
  - 4 CTRL: RW, reset 0, drives `o_ctrl`.
  - 5..15 GP: RW, reset 0.
- **Writes to RO locations:** writes to ID or ACC_CNT are dropped and set ERR.
- **Address miss (upper bits mismatch):**
  - The block still acks, so the master never hangs.
  - A read returns 32'hBADA_DD00.
  - A write is dropped.
  - ERR is set.
- **Reset:**
  - `o_wb_ack` = 0 and `io_wb_data` = Z.
  - The FSM returns to IDLE.
  - All registers are 0, except COUNTER = 0 and `o_ctrl` = 0.
  - Reset mid-transaction discards the transaction; no ack is issued.

## Timing
- Let E0 be the edge where `cyc & stb` is sampled in IDLE. The write commit and read-data register load happen at edge E0+W, where W = `WAIT_STATES`. `o_wb_ack` is high in the cycle between E(W+1) and E(W+2) is wrong; precisely, `o_wb_ack` is high for the single cycle following edge E0+W, and the master samples it at edge E0+W+1.
- Read data is registered at E0+W. It is stable and driven onto `io_wb_data` for the whole ack cycle, including COUNTER's value as of that edge.
- Back-to-back throughput: one transaction per W+2 cycles. A new `stb` is accepted in the first IDLE cycle after ACK.
- The bus is never driven when `i_wb_we` = 1, and never outside ACK.

## Structure
- **Package `wb_slave_pkg`:**
  - State enum.
  - Word-index localparams: `REG_ID`, `REG_SCRATCH`, `REG_COUNTER`, `REG_STATUS`, `REG_CTRL`.
  - `BAD_ADDR_DATA` = 32'hBADA_DD00.
  - STATUS bit positions.
- **Sub-module `wb_reg_bank`:** register storage, COUNTER, STATUS update and the read mux, with a write-strobe/index/data input and a registered read-data output. The top module keeps the FSM, the address decode and the tristate.

## Test plan
- **Reset state:** during reset, hold `cyc`/`stb` → `ack` stays 0, bus stays Z, `o_ctrl` = 0. After release, a read of word 0 (addr 0x0) with W=1 → ack at E0+1, data 32'h5742_5331.
- **Write/read-back:** write 32'hA5A5_0F0F to addr 0x10 (CTRL) → `o_ctrl` = 32'hA5A5_0F0F from the cycle after E0+W. A read of 0x10 returns the same value, and bus is Z except in the read ack cycle.
- **Miss:** read 0x0000_1000 with `BASE_ADDR` 0 → ack, data 32'hBADA_DD00, STATUS bit0 = 1. Writing STATUS with 32'h1 → bit0 = 0. ACC_CNT reads 3 after these three accesses, counting from a reset.
- **Abort:** W=3, drop `cyc` after 1 WAIT cycle during a write of 0x1234 to SCRATCH → no ack, SCRATCH unchanged, ACC_CNT unchanged.
- **COUNTER:** write 32'hFFFF_FFFE to word 2, then read 4 cycles after the write commit → 32'h0000_0002 (wrap); W=0 timing check, ack one cycle after stb.
- **Reset mid-transaction:** assert `rst` in WAIT → no ack, all registers 0, and the next request is served normally.
